// File: rtl/first_cpu_pkg.sv
// first_cpu_pkg: shared datapath types and helpers for the first_cpu core.
//   alu_op_e     : encoding of the add/subtract select line
//   MAX_STAGES   : upper bound on adder pipeline depth
//   stage_count(): number of pipeline stages for a given width/slice split
package first_cpu_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } alu_op_e;

   localparam int MAX_STAGES = 16;

   function automatic int stage_count(input int width, input int slice);
      return width / slice;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit ripple-carry adder used as one pipeline
// stage of pipelined_add_sub.
//   a, b      in  W  operand slices (b already inverted for subtract)
//   cin       in  1  carry into bit 0
//   s         out W  sum slice
//   cout      out 1  carry out of bit W-1
//   c_msb_in  out 1  carry into bit W-1 (signed-overflow detection)
module adder_slice
   import first_cpu_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         c_msb_in
);

   logic [W:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout     = c[W];
   assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit adder/subtractor split into SLICE-bit ripple
// stages with one register boundary per stage and a valid/ready handshake.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = pipe advances)
//   a, b, cin, sub       operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid/out_ready  result handshake
//   sum, cout, ovf, zero registered result and flags
//
// Stage k resolves bits [k*SLICE +: SLICE]. Its register holds the operand
// bits still to be processed (skew) and the sum bits already resolved
// (deskew), so the last stage register holds the complete aligned result.
module pipelined_add_sub
   import first_cpu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSTG = stage_count(WIDTH, SLICE);

   if ((WIDTH % SLICE) != 0 || NSTG < 1 || NSTG > MAX_STAGES) begin : g_bad_param
      $error("pipelined_add_sub: WIDTH must be a multiple of SLICE giving 1..16 stages");
   end

   logic             adv;
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic             c_msb_top;
   logic             ovf_q;
   logic             zero_q;

   // Every stage register moves together; a full output that is not being
   // taken freezes the whole pipe.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Subtract is a + ~b + ~cin, so cin behaves as an active-high borrow-in.
   assign is_sub  = (alu_op_e'(sub) == OP_SUB);
   assign b_eff   = is_sub ? ~b : b;
   assign cin_eff = is_sub ? ~cin : cin;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      logic [SLICE-1:0]       a_sl;
      logic [SLICE-1:0]       b_sl;
      logic [SLICE-1:0]       s_sl;
      logic                   ci;
      logic                   co;
      logic                   v_d;
      logic                   v_q;
      logic                   c_q;
      logic [(k+1)*SLICE-1:0] s_d;
      logic [(k+1)*SLICE-1:0] s_q;

      if (k == 0) begin : g_in
         assign a_sl = a[SLICE-1:0];
         assign b_sl = b_eff[SLICE-1:0];
         assign ci   = cin_eff;
         assign v_d  = in_valid;
         assign s_d  = s_sl;
      end else begin : g_in
         assign a_sl = g_stg[k-1].g_op.a_q[SLICE-1:0];
         assign b_sl = g_stg[k-1].g_op.b_q[SLICE-1:0];
         assign ci   = g_stg[k-1].c_q;
         assign v_d  = g_stg[k-1].v_q;
         assign s_d  = {s_sl, g_stg[k-1].s_q};
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_d;
            c_q <= co;
            s_q <= s_d;
         end
      end

      // Skew registers: operand bits for the stages still ahead, with the
      // next stage's slice at the bottom.
      if (k < NSTG - 1) begin : g_op
         localparam int RW = WIDTH - (k + 1) * SLICE;
         logic [RW-1:0] a_d;
         logic [RW-1:0] b_d;
         logic [RW-1:0] a_q;
         logic [RW-1:0] b_q;

         if (k == 0) begin : g_src
            assign a_d = a[WIDTH-1:SLICE];
            assign b_d = b_eff[WIDTH-1:SLICE];
         end else begin : g_src
            assign a_d = g_stg[k-1].g_op.a_q[WIDTH-k*SLICE-1:SLICE];
            assign b_d = g_stg[k-1].g_op.b_q[WIDTH-k*SLICE-1:SLICE];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end

      if (k == NSTG - 1) begin : g_last
         adder_slice #(.W(SLICE)) u_slice (
            .a        (a_sl),
            .b        (b_sl),
            .cin      (ci),
            .s        (s_sl),
            .cout     (co),
            .c_msb_in (c_msb_top)
         );

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv) begin
               ovf_q  <= c_msb_top ^ co;
               zero_q <= ~|s_d;
            end
         end
      end else begin : g_mid
         logic c_msb_unused;

         adder_slice #(.W(SLICE)) u_slice (
            .a        (a_sl),
            .b        (b_sl),
            .cin      (ci),
            .s        (s_sl),
            .cout     (co),
            .c_msb_in (c_msb_unused)
         );
      end
   end

   assign out_valid = g_stg[NSTG-1].v_q;
   assign sum       = g_stg[NSTG-1].s_q;
   assign cout      = g_stg[NSTG-1].c_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed and streaming checks of pipelined_add_sub
// at (16,4), (4,4) and (32,8). All three instances share the input bus;
// 'sel' picks which instance's outputs a scenario observes.
module tb_pipelined_add_sub;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a, b;
   logic        cin, sub, in_valid, out_ready;

   logic        ir16, ov16, co16, of16, z16;
   logic [15:0] s16;
   logic        ir4, ov4, co4, of4, z4;
   logic [3:0]  s4;
   logic        ir32, ov32, co32, of32, z32;
   logic [31:0] s32;

   int          sel = 0;
   int          checks = 0;
   int          failures = 0;

   logic [31:0] r_sum;
   logic        r_valid, r_cout, r_ovf, r_zero, r_ready;

   typedef struct {
      int          sel;
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic        sb;
      logic [31:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } vec_t;

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } exp_t;

   always #5 clk = ~clk;

   pipelined_add_sub #(.WIDTH(16), .SLICE(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
      .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
      .out_valid(ov16), .out_ready(out_ready),
      .sum(s16), .cout(co16), .ovf(of16), .zero(z16)
   );

   pipelined_add_sub #(.WIDTH(4), .SLICE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
      .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
      .out_valid(ov4), .out_ready(out_ready),
      .sum(s4), .cout(co4), .ovf(of4), .zero(z4)
   );

   pipelined_add_sub #(.WIDTH(32), .SLICE(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov32), .out_ready(out_ready),
      .sum(s32), .cout(co32), .ovf(of32), .zero(z32)
   );

   always_comb begin
      r_sum = '0; r_valid = 1'b0; r_cout = 1'b0; r_ovf = 1'b0; r_zero = 1'b0; r_ready = 1'b0;
      case (sel)
         1: begin
            r_sum = {28'd0, s4}; r_valid = ov4; r_cout = co4; r_ovf = of4; r_zero = z4; r_ready = ir4;
         end
         2: begin
            r_sum = s32; r_valid = ov32; r_cout = co32; r_ovf = of32; r_zero = z32; r_ready = ir32;
         end
         default: begin
            r_sum = {16'd0, s16}; r_valid = ov16; r_cout = co16; r_ovf = of16; r_zero = z16; r_ready = ir16;
         end
      endcase
   end

   function automatic int width_of(input int s);
      return (s == 1) ? 4 : ((s == 2) ? 32 : 16);
   endfunction

   function automatic int lat_of(input int s);
      return (s == 1) ? 1 : 4;
   endfunction

   // Arithmetic reference: a + b + cin, or a - b - cin, at width w.
   function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, input logic sb);
      exp_t        e;
      logic [32:0] full;
      logic [31:0] mask, xx, yy;
      logic        c0;
      mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      xx     = x & mask;
      yy     = (sb ? ~y : y) & mask;
      c0     = sb ? ~ci : ci;
      full   = {1'b0, xx} + {1'b0, yy} + {32'd0, c0};
      e.s    = full[31:0] & mask;
      e.co   = full[w];
      e.ov   = (xx[w-1] == yy[w-1]) && (e.s[w-1] != xx[w-1]);
      e.z    = (e.s == 32'd0);
      return e;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checks++;
         if ({r_valid, r_sum, r_cout, r_ovf, r_zero} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs[%0d]: valid=%b sum=%h cout=%b ovf=%b zero=%b, required all 0",
                     s, r_valid, r_sum, r_cout, r_ovf, r_zero);
         end
         checks++;
         if (r_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready[%0d]: got %b required 1", s, r_ready);
         end
      end
   endtask

   task automatic test_directed();
      vec_t v[15];
      int   n;
      bit   got;
      v[0]  = '{0, 32'h0000,     32'h0000,     1'b0, 1'b0, 32'h0000,     1'b0, 1'b0, 1'b1};
      v[1]  = '{0, 32'hFFFF,     32'h0000,     1'b1, 1'b0, 32'h0000,     1'b1, 1'b0, 1'b1};
      v[2]  = '{0, 32'h7FFF,     32'h0001,     1'b0, 1'b0, 32'h8000,     1'b0, 1'b1, 1'b0};
      v[3]  = '{0, 32'h0005,     32'h000A,     1'b0, 1'b1, 32'hFFFB,     1'b0, 1'b0, 1'b0};
      v[4]  = '{0, 32'h000A,     32'h0005,     1'b1, 1'b1, 32'h0004,     1'b1, 1'b0, 1'b0};
      v[5]  = '{0, 32'h8000,     32'h0001,     1'b0, 1'b1, 32'h7FFF,     1'b1, 1'b1, 1'b0};
      v[6]  = '{1, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
      v[7]  = '{1, 32'h5,        32'hA,        1'b0, 1'b0, 32'hF,        1'b0, 1'b0, 1'b0};
      v[8]  = '{1, 32'hF,        32'hF,        1'b1, 1'b0, 32'hF,        1'b1, 1'b0, 1'b0};
      v[9]  = '{1, 32'h7,        32'h1,        1'b0, 1'b0, 32'h8,        1'b0, 1'b1, 1'b0};
      v[10] = '{2, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
      v[11] = '{2, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1};
      v[12] = '{2, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      v[13] = '{2, 32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h01234567, 1'b1, 1'b0, 1'b0};
      v[14] = '{2, 32'h80000000, 32'h1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 15; i++) begin
         sel = v[i].sel;
         repeat (5) @(negedge clk);
         a = v[i].a; b = v[i].b; cin = v[i].ci; sub = v[i].sb; in_valid = 1'b1;
         @(posedge clk);
         #1 in_valid = 1'b0;
         got = 1'b0; n = 0;
         for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            if (r_valid === 1'b1) begin
               got = 1'b1; n = c;
            end
         end
         checks++;
         if (n != lat_of(v[i].sel)) begin
            failures++;
            $display("FAIL latency[%0d]: got %0d cycles required %0d", i, n, lat_of(v[i].sel));
         end
         checks++;
         if ({r_sum, r_cout, r_ovf, r_zero} !== {v[i].s, v[i].co, v[i].ov, v[i].z}) begin
            failures++;
            $display("FAIL result[%0d]: sum=%h c=%b v=%b z=%b required sum=%h c=%b v=%b z=%b",
                     i, r_sum, r_cout, r_ovf, r_zero, v[i].s, v[i].co, v[i].ov, v[i].z);
         end
      end
   endtask

   task automatic test_back_to_back(input int s);
      exp_t        q[$];
      exp_t        e, held;
      int          issued, popped, stall, cyc, extra;
      bit          was_stalled;
      logic        exp_ir;
      do_reset();
      sel = s;
      issued = 0; popped = 0; stall = 0; cyc = 0; was_stalled = 1'b0;
      held = '{32'd0, 1'b0, 1'b0, 1'b0};
      while ((issued < 20 || popped < 20) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (stall == 0 && (cyc == 6 || $urandom_range(0, 9) == 0)) stall = 3;
         out_ready = (stall == 0);
         if (stall > 0) stall--;
         if (issued < 20 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b0;
         end
         #1;
         exp_ir = !(r_valid && !out_ready);
         checks++;
         if (r_ready !== exp_ir) begin
            failures++;
            $display("FAIL in_ready[%0d] cyc %0d: got %b required %b", s, cyc, r_ready, exp_ir);
         end
         if (was_stalled) begin
            checks++;
            if ({r_valid, r_sum, r_cout, r_ovf, r_zero} !== {1'b1, held.s, held.co, held.ov, held.z}) begin
               failures++;
               $display("FAIL stall_hold[%0d] cyc %0d: valid=%b sum=%h required valid=1 sum=%h",
                        s, cyc, r_valid, r_sum, held.s);
            end
         end
         if (r_valid && out_ready) begin
            popped++;
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL stream_extra[%0d]: unexpected result sum=%h, required none", s, r_sum);
            end else begin
               e = q.pop_front();
               if ({r_sum, r_cout, r_ovf, r_zero} !== {e.s, e.co, e.ov, e.z}) begin
                  failures++;
                  $display("FAIL stream_result[%0d] #%0d: sum=%h c=%b v=%b z=%b required sum=%h c=%b v=%b z=%b",
                           s, popped, r_sum, r_cout, r_ovf, r_zero, e.s, e.co, e.ov, e.z);
               end
            end
         end
         if (in_valid && r_ready) begin
            q.push_back(model(width_of(s), a, b, cin, sub));
            issued++;
         end
         was_stalled = r_valid && !out_ready;
         held = '{r_sum, r_cout, r_ovf, r_zero};
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (issued != 20 || popped != 20) begin
         failures++;
         $display("FAIL stream_count[%0d]: issued=%0d popped=%0d required 20/20", s, issued, popped);
      end
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (r_valid === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         failures++;
         $display("FAIL stream_dup[%0d]: %0d extra valid cycles, required 0", s, extra);
      end
   endtask

   task automatic test_reset_midflight(input int s);
      exp_t e;
      int   n, seen;
      bit   got;
      do_reset();
      sel = s;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 32'h1234_5678 + i; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({r_valid, r_sum, r_cout, r_ovf, r_zero, r_ready} !== {36'd0, 1'b1}) begin
         failures++;
         $display("FAIL midflight_async[%0d]: valid=%b sum=%h c=%b v=%b z=%b rdy=%b, required zeros and rdy=1",
                  s, r_valid, r_sum, r_cout, r_ovf, r_zero, r_ready);
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (r_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL midflight_ghost[%0d]: %0d valid cycles after reset, required 0", s, seen);
      end
      a = 32'h1000_0003; b = 32'h0000_0004; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      e = model(width_of(s), a, b, cin, sub);
      @(posedge clk);
      #1 in_valid = 1'b0;
      got = 1'b0; n = 0;
      for (int c = 1; c <= 12 && !got; c++) begin
         @(negedge clk);
         if (r_valid === 1'b1) begin
            got = 1'b1; n = c;
         end
      end
      checks++;
      if (n != lat_of(s) || {r_sum, r_cout, r_ovf, r_zero} !== {e.s, e.co, e.ov, e.z}) begin
         failures++;
         $display("FAIL midflight_next[%0d]: latency=%0d sum=%h required latency=%0d sum=%h",
                  s, n, r_sum, lat_of(s), e.s);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      for (int s = 0; s < 3; s++) test_back_to_back(s);
      for (int s = 0; s < 3; s++) test_reset_midflight(s);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined ripple-carry adder/subtractor for the first_cpu datapath. It is the successor to the 4-bit combinational ripple adder. It splits a WIDTH-bit carry chain into SLICE-bit stages, with one register boundary per stage, so that wide adds close timing. Each stage carries a valid bit, and the whole pipe stalls under downstream backpressure. The ALU and address-increment paths consume its result and flags through a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE (elaboration-time check, `$error` otherwise).
- SLICE, 4, bits resolved per pipeline stage; NSTG = WIDTH/SLICE stages (1 ≤ NSTG ≤ 16).

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  pipe can accept operands this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out; for sub, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Effective operation:
  - add: a + b + cin.
  - sub: a + ~b + ~cin, i.e. a − b − cin; cin acts as borrow-in.
- B inversion and carry-in selection happen at capture into stage 0. Stage k adds bits [k·SLICE +: SLICE] using the registered carry from stage k−1.
- Unprocessed operand slices travel forward in skew registers. Completed sum slices travel forward in deskew registers, so `sum` is aligned at the output.
- Flags at the last stage:
  - cout = carry out of bit WIDTH−1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
- Pipe advance: `adv = ~out_valid | out_ready`. When adv=0, every stage register (data, carry, valid) holds.
- in_ready = adv, combinational from out_valid and out_ready. An input transfer occurs when in_valid & in_ready.
- Per-stage valid bits: a bubble (in_valid=0 while adv=1) enters as valid=0. Bubbles do not block later operations; stages with valid=0 still shift when adv=1.
- Outputs sum/cout/ovf/zero are registered and are don't-care when out_valid=0.
- While out_valid & ~out_ready, sum/cout/ovf/zero stay stable.

## Timing
- Latency: NSTG cycles from input transfer to out_valid, with no stall. For example, WIDTH=16, SLICE=4 gives 4 cycles.
- Throughput: one operation per cycle when out_ready is held 1.
- Reset (asynchronous assert, synchronous-to-clk deassert at the source): every valid bit = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0. in_ready = 1 immediately after reset.
- Reset mid-operation: all in-flight operations are discarded. No output is produced for them.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.
- NSTG = 1 degenerates to a single registered adder with latency 1.
- Back-to-back stall/release: no operation is lost or duplicated, and results leave in input order.

## Structure
- Package `first_cpu_pkg`:
  - typedef `alu_op_e` {OP_ADD=1'b0, OP_SUB=1'b1} for the `sub` input.
  - function `stage_count(width, slice)`.
- Sub-module `adder_slice`: combinational SLICE-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb_in (carry into its MSB, used for ovf at the top slice).
- One instance of `adder_slice` per stage, created with a generate loop.
- The top level holds the skew/deskew shift registers, valid chain and flag logic.

## Test plan
All scenarios use WIDTH=16, SLICE=4 unless stated otherwise.

- **Reset/basic add:** after reset, add a=0x0000, b=0x0000, cin=0 → exactly 4 cycles later out_valid=1, sum=0x0000, zero=1, cout=0, ovf=0.
- **Full carry ripple:** add 0xFFFF + 0x0000 + cin=1 → sum=0x0000, cout=1, zero=1. Add 0x7FFF + 0x0001 → sum=0x8000, ovf=1, cout=0.
- **Subtract/borrow:** sub 0x0005 − 0x000A, cin=0 → sum=0xFFFB, cout=0. Sub 0x000A − 0x0005 with cin=1 (borrow) → sum=0x0004, cout=1. Sub 0x8000 − 0x0001 → sum=0x7FFF, ovf=1.
- **Streaming with backpressure:** issue 20 random operations back-to-back with random in_valid gaps. Hold out_ready=0 for 3 cycles at random points. Expect results in order and matching the reference model, in_ready=0 exactly while out_valid & ~out_ready, and no loss or duplication.
- **Reset mid-flight:** issue 3 operations, assert rst_n=0 at cycle 2 → all outputs 0 asynchronously, no out_valid after release, and the next operation emerges with latency 4.
- **Parameter sweep:** repeat the scenarios above at (WIDTH=4, SLICE=4) with latency 1, using the original vectors 0101+1010+0 → sum=1111, cout=0 and 1111+1111+1 → sum=1111, cout=1. Repeat at (WIDTH=32, SLICE=8) with latency 4.
